// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit and its helpers.
package pipe_ctrl_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    PipeRun    = 2'd0,
    PipeFlush  = 2'd1,
    PipeRefill = 2'd2
  } pipe_state_e;

  // Legal width range of the per-stage stall bus (one bit per stage).
  localparam int unsigned STALL_BUS_W_MIN = 3;
  localparam int unsigned STALL_BUS_W_MAX = 8;

  // A pipeline register with bubble_o[i] set loads this instruction
  // (addi x0,x0,0) instead of the output of stage i.
  localparam logic [31:0] PIPE_NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Cycle, stall and flush performance counters; all wrap on overflow.
module pipe_perf_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_any,
  input  logic             flush_req,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Free-running cycle count plus event-gated stall and flush counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (stall_any) stall_cnt <= stall_cnt + 1'b1;
      if (flush_req) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall arbitration, branch/flush redirect and
// post-flush refill tracking.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STAGES       = 5,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic              branch_req_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  input  logic              flush_req_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] bubble_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] new_pc_o,
  output logic              new_pc_valid_o,
  output logic              refill_o,
  output logic [CNT_W-1:0]  cyc_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  pipe_state_e       state;
  logic [2:0]        flush_left;
  logic [3:0]        refill_left;
  logic [ADDR_W-1:0] new_pc_r;
  logic              pc_valid_r;

  logic [STAGES-1:0] stall_raw;
  logic [STAGES-1:0] bubble_raw;
  logic              seen;
  logic              active;
  logic              take_flush;
  logic              take_branch;

  // Priority encoder from the top stage down: every stage at or below the
  // highest requester holds, and the requester itself inserts a bubble
  // unless it is the last stage.
  always_comb begin
    stall_raw  = '0;
    bubble_raw = '0;
    seen       = 1'b0;
    for (int unsigned n = 0; n < STAGES; n++) begin
      if (stallreq_i[STAGES-1-n] && !seen && n != 0)
        bubble_raw[STAGES-1-n] = 1'b1;
      seen = seen | stallreq_i[STAGES-1-n];
      stall_raw[STAGES-1-n] = seen;
    end
  end

  assign active      = (state != PipeFlush);
  assign take_flush  = active & flush_req_i;
  assign take_branch = active & branch_req_i & ~flush_req_i & ~stall_raw[1];

  // Stall/bubble outputs are suppressed during FLUSH and in a cycle where a
  // flush is taken; an accepted branch squashes the IF/ID slot.
  always_comb begin
    stall_o  = '0;
    bubble_o = '0;
    if (active && !flush_req_i) begin
      stall_o  = stall_raw;
      bubble_o = bubble_raw;
      if (take_branch) bubble_o[0] = 1'b1;
    end
  end

  // Branch redirects are combinational; flush redirects come from the
  // register loaded when the flush was taken.
  always_comb begin
    new_pc_o       = take_branch ? branch_pc_i : new_pc_r;
    new_pc_valid_o = take_branch | pc_valid_r;
  end

  // Control FSM with registered flush/refill/redirect outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= PipeRun;
      flush_o     <= 1'b0;
      refill_o    <= 1'b0;
      new_pc_r    <= '0;
      pc_valid_r  <= 1'b0;
      flush_left  <= '0;
      refill_left <= '0;
    end else begin
      pc_valid_r <= 1'b0;
      if (take_flush) begin
        state       <= PipeFlush;
        flush_o     <= 1'b1;
        refill_o    <= 1'b0;
        new_pc_r    <= flush_pc_i;
        pc_valid_r  <= 1'b1;
        flush_left  <= 3'(FLUSH_CYCLES - 1);
        refill_left <= '0;
      end else begin
        case (state)
          PipeRun: ;
          PipeFlush: begin
            if (flush_left == '0) begin
              state       <= PipeRefill;
              flush_o     <= 1'b0;
              refill_o    <= 1'b1;
              refill_left <= 4'(STAGES - 1);
            end else begin
              flush_left <= flush_left - 1'b1;
            end
          end
          PipeRefill: begin
            if (!stall_o[0]) begin
              if (refill_left == 4'd1) begin
                state       <= PipeRun;
                refill_o    <= 1'b0;
                refill_left <= '0;
              end else begin
                refill_left <= refill_left - 1'b1;
              end
            end
          end
          default: begin
            state    <= PipeRun;
            flush_o  <= 1'b0;
            refill_o <= 1'b0;
          end
        endcase
      end
    end
  end

  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst_n     (rst),
    .stall_any (|stall_o),
    .flush_req (flush_req_i),
    .cyc_cnt   (cyc_cnt_o),
    .stall_cnt (stall_cnt_o),
    .flush_cnt (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (STAGES=5, FLUSH_CYCLES=2).
module tb_pipe_ctrl;

  localparam int unsigned STAGES = 5;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [STAGES-1:0] stallreq_i = '0;
  logic              branch_req_i = 1'b0;
  logic [ADDR_W-1:0] branch_pc_i = '0;
  logic              flush_req_i = 1'b0;
  logic [ADDR_W-1:0] flush_pc_i = '0;
  logic [STAGES-1:0] stall_o, bubble_o;
  logic              flush_o, new_pc_valid_o, refill_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic [CNT_W-1:0]  cyc_cnt_o, stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STAGES(STAGES), .ADDR_W(ADDR_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stallreq_i(stallreq_i),
    .branch_req_i(branch_req_i), .branch_pc_i(branch_pc_i),
    .flush_req_i(flush_req_i), .flush_pc_i(flush_pc_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .new_pc_o(new_pc_o), .new_pc_valid_o(new_pc_valid_o), .refill_o(refill_o),
    .cyc_cnt_o(cyc_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  // Advance to the next falling edge, leaving room for drive then sample.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({stall_o, bubble_o, flush_o, new_pc_valid_o, refill_o, new_pc_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b bubble=%b flush=%b vld=%b refill=%b pc=%h, expected all 0",
               stall_o, bubble_o, flush_o, new_pc_valid_o, refill_o, new_pc_o);
    end
    checks++;
    if ({cyc_cnt_o, stall_cnt_o, flush_cnt_o} !== '0) begin
      errors++;
      $display("FAIL reset_counters: got cyc=%0d stall=%0d flush=%0d, expected 0", cyc_cnt_o, stall_cnt_o, flush_cnt_o);
    end
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      next_cycle(); #1;
      checks++;
      if (cyc_cnt_o !== CNT_W'(i)) begin
        errors++;
        $display("FAIL cyc_count_up: got %0d expected %0d", cyc_cnt_o, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle(); next_cycle(); #1;
    checks++;
    if (cyc_cnt_o !== 32'd5) begin errors++; $display("FAIL pre_flush_cyc: got %0d expected 5", cyc_cnt_o); end
    flush_req_i = 1'b1; flush_pc_i = 32'h0000_0100;
    next_cycle();
    flush_req_i = 1'b0; #1;
    checks++;
    if ({flush_o, new_pc_valid_o} !== 2'b11 || new_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL mid_flush_entry: got flush=%b vld=%b pc=%h expected 1 1 100", flush_o, new_pc_valid_o, new_pc_o);
    end
    next_cycle(); #1;
    checks++;
    if (flush_o !== 1'b1 || cyc_cnt_o !== 32'd7) begin
      errors++;
      $display("FAIL mid_flush_hold: got flush=%b cyc=%0d expected 1 7", flush_o, cyc_cnt_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_o, bubble_o, flush_o, new_pc_valid_o, refill_o, new_pc_o, cyc_cnt_o, stall_cnt_o, flush_cnt_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: got flush=%b vld=%b refill=%b pc=%h cyc=%0d fcnt=%0d expected all 0",
               flush_o, new_pc_valid_o, refill_o, new_pc_o, cyc_cnt_o, flush_cnt_o);
    end
    next_cycle();
    rst = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      next_cycle(); #1;
      checks++;
      if (cyc_cnt_o !== CNT_W'(i) || flush_o !== 1'b0 || refill_o !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_run: got cyc=%0d flush=%b refill=%b expected %0d 0 0", cyc_cnt_o, flush_o, refill_o, i);
      end
    end
  endtask

  task automatic test_stall_priority();
    logic [STAGES-1:0] req [6] = '{5'b00100, 5'b10000, 5'b00011, 5'b01010, 5'b00001, 5'b00000};
    logic [STAGES-1:0] est [6] = '{5'b00111, 5'b11111, 5'b00011, 5'b01111, 5'b00001, 5'b00000};
    logic [STAGES-1:0] ebb [6] = '{5'b00100, 5'b00000, 5'b00010, 5'b01000, 5'b00001, 5'b00000};
    int exp_sc = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      stallreq_i = req[i];
      #1;
      checks++;
      if (stall_o !== est[i] || bubble_o !== ebb[i]) begin
        errors++;
        $display("FAIL stall_pri[%0d]: req=%b got stall=%b bubble=%b expected %b %b", i, req[i], stall_o, bubble_o, est[i], ebb[i]);
      end
      checks++;
      if (stall_cnt_o !== CNT_W'(exp_sc)) begin
        errors++;
        $display("FAIL stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt_o, exp_sc);
      end
      if (req[i] != '0) exp_sc++;
    end
    next_cycle(); #1;
    checks++;
    if (stall_cnt_o !== CNT_W'(exp_sc)) begin
      errors++;
      $display("FAIL stall_cnt_final: got %0d expected %0d", stall_cnt_o, exp_sc);
    end
  endtask

  task automatic test_branch();
    next_cycle();
    stallreq_i = '0; branch_req_i = 1'b1; branch_pc_i = 32'h0000_0040;
    #1;
    checks++;
    if (new_pc_valid_o !== 1'b1 || new_pc_o !== 32'h40 || bubble_o !== 5'b00001 || stall_o !== '0) begin
      errors++;
      $display("FAIL branch_accept: got vld=%b pc=%h bubble=%b stall=%b expected 1 40 00001 00000",
               new_pc_valid_o, new_pc_o, bubble_o, stall_o);
    end
    stallreq_i = 5'b00100;
    #1;
    checks++;
    if (new_pc_valid_o !== 1'b0 || bubble_o !== 5'b00100 || stall_o !== 5'b00111) begin
      errors++;
      $display("FAIL branch_reject: got vld=%b bubble=%b stall=%b expected 0 00100 00111", new_pc_valid_o, bubble_o, stall_o);
    end
    stallreq_i = 5'b00001;
    #1;
    checks++;
    if (new_pc_valid_o !== 1'b1 || bubble_o !== 5'b00001 || stall_o !== 5'b00001) begin
      errors++;
      $display("FAIL branch_if_stall: got vld=%b bubble=%b stall=%b expected 1 00001 00001", new_pc_valid_o, bubble_o, stall_o);
    end
    next_cycle();
    stallreq_i = '0; branch_req_i = 1'b0;
    #1;
    checks++;
    if (new_pc_valid_o !== 1'b0 || bubble_o !== '0) begin
      errors++;
      $display("FAIL branch_idle: got vld=%b bubble=%b expected 0 00000", new_pc_valid_o, bubble_o);
    end
  endtask

  task automatic test_flush_seq();
    next_cycle();
    flush_req_i = 1'b1; flush_pc_i = 32'h0000_0180;
    #1;
    checks++;
    if (new_pc_valid_o !== 1'b0 || flush_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_cycle: got vld=%b flush=%b expected 0 0", new_pc_valid_o, flush_o);
    end
    next_cycle();
    flush_req_i = 1'b0;
    #1;
    checks++;
    if (flush_o !== 1'b1 || new_pc_valid_o !== 1'b1 || new_pc_o !== 32'h180 || refill_o !== 1'b0 || flush_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL flush_first: got flush=%b vld=%b pc=%h refill=%b fcnt=%0d expected 1 1 180 0 1",
               flush_o, new_pc_valid_o, new_pc_o, refill_o, flush_cnt_o);
    end
    next_cycle();
    stallreq_i = 5'b00100; branch_req_i = 1'b1; branch_pc_i = 32'h44; flush_req_i = 1'b1;
    #1;
    checks++;
    if (flush_o !== 1'b1 || new_pc_valid_o !== 1'b0 || stall_o !== '0 || bubble_o !== '0) begin
      errors++;
      $display("FAIL flush_second: got flush=%b vld=%b stall=%b bubble=%b expected 1 0 00000 00000",
               flush_o, new_pc_valid_o, stall_o, bubble_o);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      stallreq_i = '0; branch_req_i = 1'b0; flush_req_i = 1'b0;
      #1;
      checks++;
      if (refill_o !== 1'b1 || flush_o !== 1'b0) begin
        errors++;
        $display("FAIL refill[%0d]: got refill=%b flush=%b expected 1 0", i, refill_o, flush_o);
      end
    end
    next_cycle(); #1;
    checks++;
    if (refill_o !== 1'b0 || flush_o !== 1'b0 || flush_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL refill_done: got refill=%b flush=%b fcnt=%0d expected 0 0 2", refill_o, flush_o, flush_cnt_o);
    end
  endtask

  task automatic test_refill_stall();
    next_cycle();
    flush_req_i = 1'b1; flush_pc_i = 32'h0000_0200;
    next_cycle();
    flush_req_i = 1'b0;
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      stallreq_i = (i < 3) ? 5'b00001 : 5'b00000;
      #1;
      checks++;
      if (refill_o !== 1'b1) begin
        errors++;
        $display("FAIL refill_stall[%0d]: got refill=%b expected 1", i, refill_o);
      end
      if (i < 3) begin
        checks++;
        if (stall_o !== 5'b00001 || bubble_o !== 5'b00001) begin
          errors++;
          $display("FAIL refill_stall_out[%0d]: got stall=%b bubble=%b expected 00001 00001", i, stall_o, bubble_o);
        end
      end
    end
    next_cycle(); #1;
    checks++;
    if (refill_o !== 1'b0) begin
      errors++;
      $display("FAIL refill_stall_end: got refill=%b expected 0", refill_o);
    end
  endtask

  task automatic test_branch_flush();
    next_cycle();
    branch_req_i = 1'b1; branch_pc_i = 32'h40; flush_req_i = 1'b1; flush_pc_i = 32'h300;
    #1;
    checks++;
    if (new_pc_valid_o !== 1'b0 || bubble_o !== '0) begin
      errors++;
      $display("FAIL br_fl_same: got vld=%b bubble=%b expected 0 00000", new_pc_valid_o, bubble_o);
    end
    next_cycle();
    branch_req_i = 1'b0; flush_req_i = 1'b0;
    #1;
    checks++;
    if (new_pc_valid_o !== 1'b1 || new_pc_o !== 32'h300 || flush_o !== 1'b1) begin
      errors++;
      $display("FAIL br_fl_redirect: got vld=%b pc=%h flush=%b expected 1 300 1", new_pc_valid_o, new_pc_o, flush_o);
    end
    next_cycle();
    next_cycle();
    branch_req_i = 1'b1; branch_pc_i = 32'h80;
    #1;
    checks++;
    if (refill_o !== 1'b1 || new_pc_valid_o !== 1'b1 || new_pc_o !== 32'h80 || bubble_o !== 5'b00001) begin
      errors++;
      $display("FAIL refill_branch: got refill=%b vld=%b pc=%h bubble=%b expected 1 1 80 00001",
               refill_o, new_pc_valid_o, new_pc_o, bubble_o);
    end
    next_cycle();
    branch_req_i = 1'b0; flush_req_i = 1'b1; flush_pc_i = 32'h340;
    next_cycle();
    flush_req_i = 1'b0;
    #1;
    checks++;
    if (flush_o !== 1'b1 || refill_o !== 1'b0 || new_pc_valid_o !== 1'b1 || new_pc_o !== 32'h340) begin
      errors++;
      $display("FAIL refill_reflush: got flush=%b refill=%b vld=%b pc=%h expected 1 0 1 340",
               flush_o, refill_o, new_pc_valid_o, new_pc_o);
    end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      checks++;
      if (refill_o !== 1'b1) begin
        errors++;
        $display("FAIL reflush_refill[%0d]: got refill=%b expected 1", i, refill_o);
      end
    end
    next_cycle(); #1;
    checks++;
    if (refill_o !== 1'b0 || flush_cnt_o !== 32'd5) begin
      errors++;
      $display("FAIL final_state: got refill=%b fcnt=%0d expected 0 5", refill_o, flush_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_stall_priority();
    test_branch();
    test_flush_seq();
    test_refill_stall();
    test_branch_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
